// File: rtl/sub_pkg.sv
// Shared types and sizing helpers for the digit-serial subtractor.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_DEF   = 32;
    localparam int DIGIT_W_DEF = 8;

    // Number of slices needed to cover the full operand width.
    function automatic int num_digits(input int width, input int digit_w);
        return width / digit_w;
    endfunction

    // Slice counter width; never narrower than one bit so N=1 still elaborates.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pfs_digit.sv
// One DIGIT_W-bit subtract slice: d = a - b - bin, borrow rippled bit by bit.
module pfs_digit #(
    parameter int DIGIT_W = 8
) (
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               bin,
    output logic [DIGIT_W-1:0] d,
    output logic               bout
);

    logic [DIGIT_W-1:0] g;
    logic [DIGIT_W-1:0] p;

    // Generate borrows where a=0,b=1; propagate an incoming borrow where a==b.
    assign g = ~a & b;
    assign p = a ^ b;

    // Ripple the borrow across the slice.
    always_comb begin
        logic c;
        c = bin;
        d = '0;
        for (int i = 0; i < DIGIT_W; i++) begin
            d[i] = p[i] ^ c;
            c    = g[i] | (~p[i] & c);
        end
        bout = c;
    end

endmodule

// File: rtl/sub_serial32.sv
// Digit-serial two's-complement subtractor, Diff = A - B, LSB slice first.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | in_ready=1, waiting for operands; Diff and flags hold
//   RUN   | one slice per clock, borrow carried in bin_q between slices
//   DONE  | out_valid=1, result and flags held until out_ready
module sub_serial32
    import sub_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int DIGIT_W = DIGIT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             borrow,
    output logic             zero,
    output logic             ovf,
    output logic             lt_s
);

    localparam int N  = num_digits(WIDTH, DIGIT_W);
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if ((DIGIT_W < 1) || (WIDTH % DIGIT_W != 0)) begin : g_width_check
        $error("sub_serial32: DIGIT_W must divide WIDTH exactly");
    end

    state_t             state;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [CW-1:0]      cnt;
    logic               bin_q;

    logic [DIGIT_W-1:0] a_sl;
    logic [DIGIT_W-1:0] b_sl;
    logic [DIGIT_W-1:0] d_sl;
    logic               bout;
    logic [WIDTH-1:0]   diff_nxt;
    logic               ovf_nxt;

    // Select the current operand slices from the captured operands.
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int i = 0; i < N; i++) begin
            if (cnt == CW'(i)) begin
                a_sl = a_q[i*DIGIT_W +: DIGIT_W];
                b_sl = b_q[i*DIGIT_W +: DIGIT_W];
            end
        end
    end

    pfs_digit #(
        .DIGIT_W (DIGIT_W)
    ) u_digit (
        .a    (a_sl),
        .b    (b_sl),
        .bin  (bin_q),
        .d    (d_sl),
        .bout (bout)
    );

    // Merge the new slice into the result so the flags on the last slice
    // see the complete difference, including its MSB.
    always_comb begin
        diff_nxt = Diff;
        for (int i = 0; i < N; i++) begin
            if (cnt == CW'(i)) begin
                diff_nxt[i*DIGIT_W +: DIGIT_W] = d_sl;
            end
        end
        ovf_nxt = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (diff_nxt[WIDTH-1] ^ a_q[WIDTH-1]);
    end

    // Control FSM with registered handshake, result and flag outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            Diff      <= '0;
            borrow    <= 1'b0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
            lt_s      <= 1'b0;
            cnt       <= '0;
            bin_q     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= A;
                        b_q      <= B;
                        bin_q    <= 1'b0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    Diff  <= diff_nxt;
                    bin_q <= bout;
                    if (cnt == LAST) begin
                        // Counter is left at LAST; only a new capture resets it.
                        out_valid <= 1'b1;
                        borrow    <= bout;
                        zero      <= (diff_nxt == '0);
                        ovf       <= ovf_nxt;
                        lt_s      <= diff_nxt[WIDTH-1] ^ ovf_nxt;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub_serial32.sv
// Randomized self-checking bench for sub_serial32 (default and one-slice builds).
module tb_sub_serial32;

    localparam int N_DEF = 4;

    logic        clk;
    logic        rst;

    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] A, B, Diff;
    logic        borrow, zero, ovf, lt_s;

    logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready;
    logic [31:0] w_A, w_B, w_Diff;
    logic        w_borrow, w_zero, w_ovf, w_lt_s;

    int n_checks;
    int n_errors;

    sub_serial32 u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Diff      (Diff),
        .borrow    (borrow),
        .zero      (zero),
        .ovf       (ovf),
        .lt_s      (lt_s)
    );

    sub_serial32 #(
        .WIDTH   (32),
        .DIGIT_W (32)
    ) u_dut_w (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (w_in_valid),
        .in_ready  (w_in_ready),
        .A         (w_A),
        .B         (w_B),
        .out_valid (w_out_valid),
        .out_ready (w_out_ready),
        .Diff      (w_Diff),
        .borrow    (w_borrow),
        .zero      (w_zero),
        .ovf       (w_ovf),
        .lt_s      (w_lt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain integer subtraction and signed/unsigned comparisons.
    task automatic model(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] d, output logic bo, output logic z,
                         output logic ov, output logic lt);
        d  = a - b;
        bo = (a < b);
        z  = (a == b);
        lt = ($signed(a) < $signed(b));
        ov = lt ^ d[31];
    endtask

    task automatic check_result(input string pfx, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] d, input logic bo, input logic z,
                                input logic ov, input logic lt);
        logic [31:0] ed;
        logic        eb, ez, eo, el;
        model(a, b, ed, eb, ez, eo, el);
        chk({pfx, "_diff"},   d,  ed);
        chk({pfx, "_borrow"}, {31'd0, bo}, {31'd0, eb});
        chk({pfx, "_zero"},   {31'd0, z},  {31'd0, ez});
        chk({pfx, "_ovf"},    {31'd0, ov}, {31'd0, eo});
        chk({pfx, "_lt_s"},   {31'd0, lt}, {31'd0, el});
    endtask

    // One operation on the default build; stall>0 holds out_ready low in DONE
    // for that many cycles while offering junk operands.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int stall);
        int          t;
        int          lat;
        logic [31:0] d_hold;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("idle_ready", {31'd0, in_ready}, 32'd1);
        A         = a;
        B         = b;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        @(posedge clk);
        #1;
        chk("accept_drops_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        A        = $urandom;
        B        = $urandom;
        lat      = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            if (!out_valid) lat++;
        end
        chk("latency", lat, N_DEF);
        check_result("res", a, b, Diff, borrow, zero, ovf, lt_s);
        d_hold = Diff;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            A        = $urandom;
            B        = $urandom;
            @(posedge clk);
            #1;
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_ready", {31'd0, in_ready}, 32'd0);
            check_result("bp", a, b, Diff, borrow, zero, ovf, lt_s);
        end
        if (stall > 0) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("release_valid", {31'd0, out_valid}, 32'd0);
        chk("release_ready", {31'd0, in_ready}, 32'd1);
        chk("idle_diff_hold", Diff, d_hold);
        if (stall > 0) begin
            // The junk operands offered in DONE must not start an operation.
            repeat (N_DEF + 1) begin
                @(posedge clk);
                #1;
                chk("no_extra_result", {31'd0, out_valid}, 32'd0);
            end
        end
        @(negedge clk);
    endtask

    task automatic run_op_w(input logic [31:0] a, input logic [31:0] b);
        int lat;
        @(negedge clk);
        chk("w_idle_ready", {31'd0, w_in_ready}, 32'd1);
        w_A         = a;
        w_B         = b;
        w_in_valid  = 1'b1;
        w_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        w_in_valid = 1'b0;
        lat = 0;
        while (!w_out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("w_latency", lat, 1);
        check_result("w", a, b, w_Diff, w_borrow, w_zero, w_ovf, w_lt_s);
        @(posedge clk);
        #1;
        chk("w_release", {31'd0, w_out_valid}, 32'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int          t;
        logic [31:0] ra, rb;
        n_checks    = 0;
        n_errors    = 0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        A           = '0;
        B           = '0;
        w_in_valid  = 1'b0;
        w_out_ready = 1'b1;
        w_A         = '0;
        w_B         = '0;

        #12;
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_diff",      Diff, 32'd0);
        chk("rst_flags",     {28'd0, borrow, zero, ovf, lt_s}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases.
        run_op(32'd5, 32'd3, 0);
        chk("dir_5m3", Diff, 32'h0000_0002);
        run_op(32'd3, 32'd5, 0);
        chk("dir_3m5", Diff, 32'hFFFF_FFFE);
        run_op(32'h0000_0100, 32'd1, 0);
        chk("dir_slice_borrow", Diff, 32'h0000_00FF);
        run_op(32'h8000_0000, 32'd1, 0);
        chk("dir_ovf", {31'd0, ovf}, 32'd1);
        run_op(32'h1234_5678, 32'h1234_5678, 0);
        chk("dir_zero", {31'd0, zero}, 32'd1);

        // Backpressure with junk operands offered in DONE.
        run_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 5);

        // Reset two cycles after accept.
        A         = 32'd100;
        B         = 32'd1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrun_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrun_rst_ready", {31'd0, in_ready}, 32'd1);
        chk("midrun_rst_diff",  Diff, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op(32'd10, 32'd7, 0);
        chk("after_rst_diff", Diff, 32'd3);

        // Throughput: in_valid held high, out_ready high -> accepts N+2 apart.
        A        = 32'd9;
        B        = 32'd4;
        in_valid = 1'b1;
        @(posedge clk);
        t = 0;
        do begin
            @(posedge clk);
            #1;
            t++;
        end while (!in_ready && t < 20);
        chk("tput_ready_back", t, N_DEF + 1);
        @(posedge clk);
        #1;
        chk("tput_reaccept", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        t = 0;
        while (!out_valid && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        check_result("tput", 32'd9, 32'd4, Diff, borrow, zero, ovf, lt_s);
        @(negedge clk);
        @(negedge clk);

        // Randomized operations with occasional backpressure.
        for (int k = 0; k < 40; k++) begin
            ra = pick();
            rb = ($urandom_range(0, 9) == 0) ? ra : pick();
            run_op(ra, rb, ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0);
        end

        // One-slice build.
        run_op_w(32'd0, 32'd1);
        chk("w_dir_diff", w_Diff, 32'hFFFF_FFFF);
        for (int k = 0; k < 10; k++) begin
            run_op_w(pick(), pick());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sub_serial32.md
Name: sub_serial32

Overview:
- Digit-serial 32-bit two's-complement subtractor computing Diff = A - B with borrow propagation.
- Processes one DIGIT_W-bit slice per clock, LSB first; the borrow is carried in a register between slices.
- Used where area matters more than latency, and as the compare/subtract engine for iterative arithmetic next to the parallel adders.
- Valid/ready handshake on both the operand side and the result side.

Parameters:
WIDTH, 32, operand and result width
DIGIT_W, 8, bits processed per cycle; must divide WIDTH exactly (elaboration-time check)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  operands A, B presented
in_ready  out  1  block can accept operands
A  in  WIDTH  minuend
B  in  WIDTH  subtrahend
out_valid  out  1  result fields valid
out_ready  in  1  consumer accepts result
Diff  out  WIDTH  A - B modulo 2^WIDTH
borrow  out  1  final borrow out; 1 means A < B unsigned
zero  out  1  Diff == 0
ovf  out  1  signed overflow
lt_s  out  1  A < B signed, equal to Diff[WIDTH-1] ^ ovf

Behaviour:
- One clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state IDLE, in_ready=1, out_valid=0, Diff=0, borrow=0, zero=0, ovf=0, lt_s=0, digit counter=0, borrow register=0.
- States:
  - IDLE: in_ready=1. On in_valid, capture A, B; clear the borrow register and counter; go to RUN.
  - RUN: in_ready=0. Each edge processes slice cnt:
    - p = a ^ b
    - d = p ^ bin
    - bout = (~a & b) | (~p & bin), rippled bitwise within the slice
    - Write d into Diff[cnt*DIGIT_W +: DIGIT_W], store the slice borrow-out, increment cnt.
    - After the slice with cnt = N-1 (N = WIDTH/DIGIT_W), go to DONE.
  - DONE: out_valid=1. borrow, zero, ovf and lt_s are registered on the RUN->DONE edge.
    - ovf = (A[msb] != B[msb]) & (Diff[msb] != A[msb]).
    - On out_ready, go to IDLE and drop out_valid.
- Latency: out_valid rises exactly N cycles after the accepting edge (4 cycles at defaults). With DIGIT_W = WIDTH it is 1 cycle.
- Throughput: one operation per N+2 cycles when out_ready is held high. in_ready is asserted only in IDLE, so there is no overlap of accept and output.
- in_valid while in RUN or DONE is ignored. Captured operands are not affected by later changes on A/B.
- Backpressure: in DONE with out_ready=0, all outputs hold stable indefinitely.
- out_ready while not in DONE has no effect.
- Diff bits are undefined-but-stable while in RUN; consumers use them only when out_valid=1. Diff holds its last value in IDLE.
- Wrap-around: results are modulo 2^WIDTH. The counter wraps to 0 only via IDLE capture, never by overflow.
- rst asserted mid-RUN or mid-DONE: immediate return to reset values; the in-flight operation is dropped with no partial result.

Decomposition:
- Package sub_pkg holds:
  - state typedef: enum {IDLE, RUN, DONE}
  - WIDTH default
  - function computing N = WIDTH/DIGIT_W
  - counter width = $clog2(N) with a minimum of 1
- One combinational sub-module, pfs_digit (DIGIT_W generic): inputs a, b, bin; outputs d, bout. It uses the same generate/propagate ripple style as the parallel adder.
- sub_serial32 holds the FSM, the operand and result registers, and the flag logic.

Test Plan:
- A=5, B=3, out_ready=1 -> Diff=0x00000002, borrow=0, zero=0, ovf=0, lt_s=0; out_valid exactly 4 cycles after accept.
- A=3, B=5 -> Diff=0xFFFFFFFE, borrow=1, lt_s=1, ovf=0. Also A=0x00000100, B=1 -> Diff=0x000000FF (borrow crosses slice boundary).
- A=0x80000000, B=1 -> Diff=0x7FFFFFFF, ovf=1, lt_s=1, borrow=0. A=0x12345678, B=0x12345678 -> Diff=0, zero=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE and pulse in_valid with new operands -> outputs unchanged, in_ready=0, new operands not captured; a result is produced only for the first operation.
- Reset mid-RUN: assert rst 2 cycles after accept -> out_valid=0 and in_ready=1 immediately. Then A=10, B=7 -> Diff=3, borrow=0.
- DIGIT_W=32 build: A=0, B=1 -> Diff=0xFFFFFFFF, borrow=1; out_valid 1 cycle after accept.
